// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the register file and its neighbours (ALU, decoder, control).
// Replaces the old cpu_defs.vh include.
package reg_file_pkg;

    localparam int unsigned CPU_DATA_W   = 32;
    localparam int unsigned CPU_ADDR_W   = 5;
    localparam int unsigned CPU_NUM_REGS = 2 ** CPU_ADDR_W;

    localparam logic [CPU_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file port bundle: one write port and two combinational read ports.
// master = datapath/controller side, slave = register file.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/reg_file_word.sv
// One register-file entry: DATA_W-bit register with write enable and async active-low clear.
module reg_word
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (we) begin
            data_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rdata = data_q;

endmodule

// File: rtl/reg_file.sv
// 32-entry GPR file: R0 hardwired to zero, one write port, two combinational read ports
// with optional same-cycle write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:1]             wr_en;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            wr_valid;
    logic                            byp1;
    logic                            byp2;

    // Each enable is ANDed with RegWrite so an unknown WriteReg cannot reach any entry.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            wr_en[i] = bus.RegWrite & (bus.WriteReg == ADDR_W'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
        reg_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en[g]),
            .wdata (bus.WriteData),
            .rdata (regs[g])
        );
    end

    // Bypass is suppressed while in reset so reads stay at zero.
    assign wr_valid = rst_n && bus.RegWrite && (bus.WriteReg != ADDR_W'(REG_ZERO));
    assign byp1     = BYPASS && wr_valid && (bus.ReadReg1 == bus.WriteReg);
    assign byp2     = BYPASS && wr_valid && (bus.ReadReg2 == bus.WriteReg);

    always_comb begin
        bus.ReadData1 = regs[bus.ReadReg1];
        if (byp1) begin
            bus.ReadData1 = bus.WriteData;
        end
        if (!rst_n || (bus.ReadReg1 == ADDR_W'(REG_ZERO))) begin
            bus.ReadData1 = '0;
        end
    end

    always_comb begin
        bus.ReadData2 = regs[bus.ReadReg2];
        if (byp2) begin
            bus.ReadData2 = bus.WriteData;
        end
        if (!rst_n || (bus.ReadReg2 == ADDR_W'(REG_ZERO))) begin
            bus.ReadData2 = '0;
        end
    end

endmodule
